// File: rtl/i2c_slave_if.sv
// I2C target bus/handshake bundle.
// Carries the pin levels (scl_i, sda_i, sda_o), the enable and own address,
// and the rx/tx byte handshakes between the target and its local user.
// Modports:
//   slave  - the i2c_slave side (pins in, SDA drive and byte handshakes out)
//   master - the user/bench side (drives pins, enable, address, tx byte)
interface i2c_slave_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);
  logic                  en_i;
  logic [ADDR_WIDTH-1:0] self_addr_i;
  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_req_o;
  logic                  busy_o;

  modport slave (
    input  en_i, self_addr_i, scl_i, sda_i, tx_data_i,
    output sda_o, rx_data_o, rx_valid_o, tx_req_o, busy_o
  );

  modport master (
    output en_i, self_addr_i, scl_i, sda_i, tx_data_i,
    input  sda_o, rx_data_o, rx_valid_o, tx_req_o, busy_o
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target, 7-bit addressing, no clock stretching.
// Oversamples SCL/SDA on clk_i, detects START/STOP, matches the address,
// ACKs, then delivers written bytes (rx_data_o/rx_valid_o) or serves read
// bytes (tx_data_i latched on tx_req_o).
// Ports:
//   clk_i     - system clock, >= 16x SCL
//   a_rst_n_i - asynchronous active-low reset
//   bus       - i2c_slave_if.slave: en_i, self_addr_i, scl_i, sda_i, sda_o,
//               rx_data_o, rx_valid_o, tx_data_i, tx_req_o, busy_o
module i2c_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         a_rst_n_i,
  i2c_slave_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic                  sda_q, sda_nxt;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_nxt;
  logic                  rx_valid_q, rx_valid_nxt;
  logic                  tx_req_q, tx_req_nxt;
  logic                  busy_q, busy_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [DATA_WIDTH-1:0] tx_sh, tx_sh_nxt;
  logic                  rw_q, rw_nxt;
  // Pending flag: ADDR/WRITE = byte complete, ACK due on next fall;
  // READ_ACK = master ACKed, reload on next fall.
  logic                  pend, pend_nxt;

  logic [DATA_WIDTH-1:0] byte_in;
  logic                  addr_match;
  logic                  last_bit;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign start_det  = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det   = scl_s & scl_prev & ~sda_prev & sda_s;
  assign byte_in    = {shreg[DATA_WIDTH-2:0], sda_s};
  assign addr_match = (byte_in[DATA_WIDTH-1:1] == bus.self_addr_i);
  assign last_bit   = (bit_cnt == 3'd7);

  // State register plus the datapath registers computed by the output logic
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_prev   <= 1'b1;
      sda_prev   <= 1'b1;
      state      <= S_IDLE;
      sda_q      <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx_sh      <= '0;
      rw_q       <= 1'b0;
      pend       <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_prev   <= scl_s;
      sda_prev   <= sda_s;
      state      <= state_nxt;
      sda_q      <= sda_nxt;
      rx_data_q  <= rx_data_nxt;
      rx_valid_q <= rx_valid_nxt;
      tx_req_q   <= tx_req_nxt;
      busy_q     <= busy_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      tx_sh      <= tx_sh_nxt;
      rw_q       <= rw_nxt;
      pend       <= pend_nxt;
    end
  end

  // Next-state logic; disable, START and STOP take priority over bit events
  always_comb begin
    state_nxt = state;
    if (!bus.en_i)      state_nxt = S_IDLE;
    else if (start_det) state_nxt = S_ADDR;
    else if (stop_det)  state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:      state_nxt = S_IDLE;
        S_ADDR: begin
          if (scl_rise && last_bit && !addr_match) state_nxt = S_WAIT;
          else if (scl_fall && pend)               state_nxt = S_ADDR_ACK;
        end
        S_ADDR_ACK:  if (scl_fall) state_nxt = rw_q ? S_READ : S_WRITE;
        S_WRITE:     if (scl_fall && pend) state_nxt = S_WRITE_ACK;
        S_WRITE_ACK: if (scl_fall) state_nxt = S_WRITE;
        S_READ:      if (scl_fall && last_bit) state_nxt = S_READ_ACK;
        S_READ_ACK: begin
          if (scl_rise && sda_s)     state_nxt = S_WAIT;
          else if (scl_fall && pend) state_nxt = S_READ;
        end
        S_WAIT:      state_nxt = S_WAIT;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    sda_nxt      = sda_q;
    rx_data_nxt  = rx_data_q;
    rx_valid_nxt = 1'b0;
    tx_req_nxt   = 1'b0;
    busy_nxt     = busy_q;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    tx_sh_nxt    = tx_sh;
    rw_nxt       = rw_q;
    pend_nxt     = pend;
    if (!bus.en_i || start_det || stop_det) begin
      sda_nxt     = 1'b1;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = '0;
      pend_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_WAIT: sda_nxt = 1'b1;
        S_ADDR: begin
          if (scl_rise) begin
            shreg_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (last_bit && addr_match) begin
              busy_nxt = 1'b1;
              pend_nxt = 1'b1;
              rw_nxt   = sda_s;
            end
          end else if (scl_fall && pend) begin
            sda_nxt  = 1'b0;
            pend_nxt = 1'b0;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = '0;
            if (rw_q) begin
              tx_req_nxt = 1'b1;
              sda_nxt    = bus.tx_data_i[DATA_WIDTH-1];
              tx_sh_nxt  = {bus.tx_data_i[DATA_WIDTH-2:0], 1'b0};
            end else begin
              sda_nxt = 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (scl_rise) begin
            shreg_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (last_bit) begin
              rx_data_nxt  = byte_in;
              rx_valid_nxt = 1'b1;
              pend_nxt     = 1'b1;
            end
          end else if (scl_fall && pend) begin
            sda_nxt  = 1'b0;
            pend_nxt = 1'b0;
          end
        end
        S_WRITE_ACK: begin
          if (scl_fall) begin
            sda_nxt     = 1'b1;
            bit_cnt_nxt = '0;
          end
        end
        S_READ: begin
          // MSB went out on entry; falls 1..7 drive the rest, fall 8 releases
          if (scl_fall) begin
            if (last_bit) begin
              sda_nxt     = 1'b1;
              bit_cnt_nxt = '0;
            end else begin
              sda_nxt     = tx_sh[DATA_WIDTH-1];
              tx_sh_nxt   = {tx_sh[DATA_WIDTH-2:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            pend_nxt = ~sda_s;
          end else if (scl_fall && pend) begin
            pend_nxt    = 1'b0;
            tx_req_nxt  = 1'b1;
            sda_nxt     = bus.tx_data_i[DATA_WIDTH-1];
            tx_sh_nxt   = {bus.tx_data_i[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_nxt = '0;
          end
        end
        default: begin
          sda_nxt     = 1'b1;
          rx_data_nxt = '0;
          busy_nxt    = 1'b0;
          bit_cnt_nxt = '0;
          pend_nxt    = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_o      = sda_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.tx_req_o   = tx_req_q;
  assign bus.busy_o     = busy_q;

endmodule
